// File: rtl/inst_fetch.sv
// inst_fetch: PC, imem credit handshake, in-order instruction queue.
// Optional FETCH_ADEL_EN: misaligned redirect yields one NOP entry flagged if_adel.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned QDEPTH   = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        if_adel
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] QLIM = (CW+1)'(QDEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0] tw_q, tw_d, tr_q, tr_d;

  logic [31:0] tag_q [QDEPTH];
  logic [31:0] pcm_q [QDEPTH];
  logic [31:0] insm_q [QDEPTH];

  logic          credit, accept, rv, keep, pop;
  logic          push;
  logic [PW-1:0] push_idx;
  logic [31:0]   push_pc, push_inst;
  logic [31:0]   fetch_pc;

`ifdef FETCH_ADEL_EN
  logic halt_q, halt_d;
  logic push_adel;
  logic adm_q [QDEPTH];
`endif

  assign credit = ({1'b0, out_q} + {1'b0, cnt_q}) < QLIM;

`ifdef FETCH_ADEL_EN
  assign fetch_pc = pc_q;
  assign imem_req = !rst && !halt_q && credit;
`else
  assign fetch_pc = {pc_q[31:2], 2'b00};
  assign imem_req = !rst && credit;
`endif

  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;
  assign rv        = imem_rvalid && (out_q != '0);
  assign keep      = rv && (drop_q == '0);
  assign pop       = if_valid && id_ready && !redirect_valid;

  assign if_valid = cnt_q != '0;
  assign if_pc    = if_valid ? pcm_q[rd_q] : '0;
  assign if_inst  = if_valid ? insm_q[rd_q] : '0;
`ifdef FETCH_ADEL_EN
  assign if_adel  = if_valid && adm_q[rd_q];
`else
  assign if_adel  = 1'b0;
`endif

  // next-state: credit/accept, response drop/push, pop, redirect override
  always_comb begin
    pc_d      = pc_q;
    out_d     = out_q + CW'(accept) - CW'(rv);
    drop_d    = drop_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q + CW'(keep) - CW'(pop);
    tw_d      = tw_q + PW'(accept);
    tr_d      = tr_q + PW'(rv);
    push      = keep;
    push_idx  = wr_q;
    push_pc   = tag_q[tr_q];
    push_inst = imem_rdata;
`ifdef FETCH_ADEL_EN
    halt_d    = halt_q;
    push_adel = 1'b0;
`endif
    if (accept)
      pc_d = pc_q + 32'd4;
    if (rv && (drop_q != '0))
      drop_d = drop_q - CW'(1);
    if (keep)
      wr_d = wr_q + PW'(1);
    if (pop)
      rd_d = rd_q + PW'(1);
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      drop_d = out_d;
      push   = 1'b0;
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
`ifdef FETCH_ADEL_EN
      halt_d = |redirect_pc[1:0];
      if (|redirect_pc[1:0]) begin
        push      = 1'b1;
        push_idx  = '0;
        push_pc   = redirect_pc;
        push_inst = NOP_INST;
        push_adel = 1'b1;
        wr_d      = PW'(1);
        cnt_d     = CW'(1);
      end
`endif
    end
  end

  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      tw_q   <= '0;
      tr_q   <= '0;
`ifdef FETCH_ADEL_EN
      halt_q <= 1'b0;
`endif
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      tw_q   <= tw_d;
      tr_q   <= tr_d;
`ifdef FETCH_ADEL_EN
      halt_q <= halt_d;
`endif
    end
  end

  // tag FIFO and instruction queue storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        tag_q[i]  <= '0;
        pcm_q[i]  <= '0;
        insm_q[i] <= NOP_INST;
`ifdef FETCH_ADEL_EN
        adm_q[i]  <= 1'b0;
`endif
      end
    end else begin
      if (accept)
        tag_q[tw_q] <= fetch_pc;
      if (push) begin
        pcm_q[push_idx]  <= push_pc;
        insm_q[push_idx] <= push_inst;
`ifdef FETCH_ADEL_EN
        adm_q[push_idx]  <= push_adel;
`endif
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: random/directed stimulus vs. a stream scoreboard.
// Memory model returns addr^32'h1234 after a fixed latency, in order.
module tb_inst_fetch;

  localparam logic [31:0] RPC = 32'hBFC0_0000;
  localparam logic [31:0] KEY = 32'h0000_1234;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
  logic        if_adel;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rcyc = 0;
  int first_valid = -1;
  int nacc = 0;
  int ndeliv = 0;
  int lat = 1;
  int rdy_pct = 100;
  logic [31:0] exp_pc = RPC;
  logic [31:0] exp_addr = RPC;
  logic [31:0] mq[$];
  int          dq[$];
  logic [31:0] dpc[$];

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(id_ready), .if_adel(if_adel)
  );

  // one clock: drive at negedge, check, update model, advance
  task automatic cycle(input bit rd, input logic [31:0] rpc,
                       input bit idr);
    redirect_valid = rd;
    redirect_pc    = rpc;
    id_ready       = idr;
    imem_ready     = ($urandom_range(99) < rdy_pct);
    if (mq.size() > 0 && dq[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0] ^ KEY;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    if (imem_req === 1'b1) begin
      tests++;
      if (imem_addr !== exp_addr) begin
        fails++;
        $display("FAIL req_addr: got %h want %h", imem_addr, exp_addr);
      end
    end
    if (if_valid === 1'b1 && first_valid < 0)
      first_valid = cyc - rcyc;
    if (if_valid === 1'b1 && idr && !rd) begin
      tests++;
      if (if_pc !== exp_pc) begin
        fails++;
        $display("FAIL deliver_pc: got %h want %h", if_pc, exp_pc);
      end
      tests++;
      if (if_inst !== (exp_pc ^ KEY)) begin
        fails++;
        $display("FAIL deliver_inst: got %h want %h",
                 if_inst, exp_pc ^ KEY);
      end
      dpc.push_back(if_pc);
      ndeliv++;
      exp_pc = exp_pc + 32'd4;
    end
    if (imem_rvalid) begin
      void'(mq.pop_front());
      void'(dq.pop_front());
    end
    if (imem_req === 1'b1 && imem_ready) begin
      mq.push_back(imem_addr);
      dq.push_back(cyc + lat);
      nacc++;
      exp_addr = exp_addr + 32'd4;
    end
    if (rd) begin
      exp_pc   = rpc;
      exp_addr = rpc;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    imem_ready     = 1'b1;
    imem_rvalid    = 1'b1;
    imem_rdata     = $urandom;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({imem_req, if_valid, if_adel} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: got %b want 000",
               {imem_req, if_valid, if_adel});
    end
    tests++;
    if ({if_inst, if_pc} !== 64'h0) begin
      fails++;
      $display("FAIL reset_data: got %h/%h want 0/0", if_inst, if_pc);
    end
    mq.delete();
    dq.delete();
    dpc.delete();
    rst         = 1'b0;
    imem_rvalid = 1'b0;
    exp_pc      = RPC;
    exp_addr    = RPC;
    rcyc        = cyc;
    first_valid = -1;
  endtask

  task automatic test_reset;
    lat = 1;
    rdy_pct = 100;
    do_reset();
    #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      fails++;
      $display("FAIL reset_first_req: got %b/%h want 1/%h",
               imem_req, imem_addr, RPC);
    end
  endtask

  task automatic test_stream;
    int d0;
    lat = 1;
    rdy_pct = 100;
    do_reset();
    d0 = ndeliv;
    repeat (24) cycle(1'b0, '0, 1'b1);
    tests++;
    if (first_valid != 2) begin
      fails++;
      $display("FAIL first_latency: got %0d want 2", first_valid);
    end
    tests++;
    if (ndeliv - d0 < 14) begin
      fails++;
      $display("FAIL stream_count: got %0d want >=14", ndeliv - d0);
    end
    tests++;
    if (dpc.size() < 3 || dpc[2] !== RPC + 32'd8) begin
      fails++;
      $display("FAIL stream_third_pc: got %0d entries want pc %h",
               dpc.size(), RPC + 32'd8);
    end
  endtask

  task automatic test_backpressure;
    int n0;
    lat = 1;
    rdy_pct = 100;
    do_reset();
    n0 = nacc;
    repeat (10) cycle(1'b0, '0, 1'b0);
    tests++;
    if (nacc - n0 != 2) begin
      fails++;
      $display("FAIL bp_requests: got %0d want 2", nacc - n0);
    end
    tests++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_stall: got req=%b valid=%b want 0/1",
               imem_req, if_valid);
    end
    repeat (12) cycle(1'b0, '0, 1'b1);
    tests++;
    if (dpc.size() < 3 || dpc[0] !== RPC || dpc[1] !== RPC + 32'd4
        || dpc[2] !== RPC + 32'd8) begin
      fails++;
      $display("FAIL bp_order: got %0d entries want %h,%h,%h",
               dpc.size(), RPC, RPC + 32'd4, RPC + 32'd8);
    end
  endtask

  task automatic test_redirect_inflight;
    lat = 3;
    rdy_pct = 100;
    do_reset();
    for (int i = 0; i < 20 && mq.size() < 2; i++)
      cycle(1'b0, '0, 1'b0);
    tests++;
    if (mq.size() != 2) begin
      fails++;
      $display("FAIL inflight_setup: got %0d want 2", mq.size());
    end
    dpc.delete();
    cycle(1'b1, 32'h0000_0100, 1'b1);
    repeat (15) cycle(1'b0, '0, 1'b1);
    tests++;
    if (dpc.size() == 0 || dpc[0] !== 32'h0000_0100) begin
      fails++;
      $display("FAIL inflight_first: got %0d entries want %h",
               dpc.size(), 32'h0000_0100);
    end
  endtask

  task automatic test_redirect_same_cycle;
    bit found;
    lat = 1;
    rdy_pct = 100;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (imem_req === 1'b1 && mq.size() > 0 && dq[0] <= cyc) begin
        found = 1'b1;
        break;
      end
      cycle(1'b0, '0, 1'b1);
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL same_setup: got none want req+rvalid cycle");
    end
    dpc.delete();
    cycle(1'b1, 32'h0000_0200, 1'b1);
    tests++;
    if (if_valid !== 1'b0) begin
      fails++;
      $display("FAIL same_flush: got %b want 0", if_valid);
    end
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
      fails++;
      $display("FAIL same_addr: got %b/%h want 1/%h",
               imem_req, imem_addr, 32'h0000_0200);
    end
    repeat (10) cycle(1'b0, '0, 1'b1);
    tests++;
    if (dpc.size() == 0 || dpc[0] !== 32'h0000_0200) begin
      fails++;
      $display("FAIL same_first: got %0d entries want %h",
               dpc.size(), 32'h0000_0200);
    end
  endtask

  task automatic test_wrap;
    lat = 1;
    rdy_pct = 100;
    dpc.delete();
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (12) cycle(1'b0, '0, 1'b1);
    tests++;
    if (dpc.size() < 2 || dpc[0] !== 32'hFFFF_FFFC
        || dpc[1] !== 32'h0) begin
      fails++;
      $display("FAIL wrap: got %0d entries want FFFFFFFC,00000000",
               dpc.size());
    end
  endtask

  task automatic test_random;
    int d0;
    bit rd;
    logic [31:0] rpc;
    for (int l = 1; l <= 3; l++) begin
      lat = l;
      rdy_pct = 70;
      do_reset();
      d0 = ndeliv;
      for (int i = 0; i < 300; i++) begin
        rd  = ($urandom_range(29) == 0);
        rpc = $urandom;
        rpc[1:0] = 2'b00;
        cycle(rd, rpc, $urandom_range(3) != 0);
      end
      tests++;
      if (ndeliv - d0 < 30) begin
        fails++;
        $display("FAIL random_progress: got %0d want >=30",
                 ndeliv - d0);
      end
    end
  endtask

`ifdef FETCH_ADEL_EN
  task automatic test_adel;
    lat = 1;
    rdy_pct = 100;
    do_reset();
    repeat (3) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'h0000_0102, 1'b0);
    tests++;
    if ({if_valid, if_adel} !== 2'b11 || if_inst !== 32'h0
        || if_pc !== 32'h0000_0102) begin
      fails++;
      $display("FAIL adel_entry: got %b%b %h %h want 11 0 00000102",
               if_valid, if_adel, if_inst, if_pc);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b0);
      tests++;
      if (imem_req !== 1'b0) begin
        fails++;
        $display("FAIL adel_halt: got %b want 0", imem_req);
      end
    end
    cycle(1'b1, 32'h0000_0200, 1'b1);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200
        || if_adel !== 1'b0) begin
      fails++;
      $display("FAIL adel_resume: got %b/%h/%b want 1/00000200/0",
               imem_req, imem_addr, if_adel);
    end
    repeat (6) cycle(1'b0, '0, 1'b1);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_wrap();
    test_random();
`ifdef FETCH_ADEL_EN
    test_adel();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
